// File: rtl/vga_if.sv
// Pixel-stream bundle carried from the raster generator through the overlay stages.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        vblnk;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  // Source end: the timing generator or an overlay stage driving the next one.
  modport out (
    output vcount, hcount, vsync, vblnk, hsync, hblnk, rgb
  );

  // Sink end: an overlay stage or the display output.
  modport in (
    input vcount, hcount, vsync, vblnk, hsync, hblnk, rgb
  );
endinterface

// File: rtl/vga_timing.sv
// Raster timing source: registered pixel/line counters with sync and blank
// decode, a black background, a frame-start strobe and a pixel-advance enable.
module vga_timing #(
  parameter int   H_ACTIVE = 800,
  parameter int   H_FP     = 40,
  parameter int   H_SYNC   = 128,
  parameter int   H_BP     = 88,
  parameter int   V_ACTIVE = 600,
  parameter int   V_FP     = 1,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 23,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic frame_start,
  vga_if.out   out
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOT - 1);
  localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Reject timings with an empty porch/sync region or totals that overflow 11 bits.
  if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0 ||
      H_TOT >= 2048 || V_TOT >= 2048) begin : g_param_check
    $error("vga_timing: porch/sync widths must be > 0 and H_TOT/V_TOT < 2048");
  end

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;

  // Next raster position plus the decode of that position, so sync/blank
  // land in the same register stage as the counters they describe.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;

    if (en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 11'd1;
        end
      end else begin
        hcount_d = hcount_q + 11'd1;
      end
    end

    hblnk_d = (hcount_d >= H_BLNK_BEG);
    hsync_d = ((hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    vblnk_d = (vcount_d >= V_BLNK_BEG);
    vsync_d = ((vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Raster state register with synchronous reset to (0,0), sync inactive.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign out.hcount  = hcount_q;
  assign out.vcount  = vcount_q;
  assign out.hsync   = hsync_q;
  assign out.vsync   = vsync_q;
  assign out.hblnk   = hblnk_q;
  assign out.vblnk   = vblnk_q;
  assign out.rgb     = 12'h000;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default timing, short frame, and
// short frame with negative sync) share one stimulus stream. Expected pixels
// are queued per instance as stimulus is issued; a negedge monitor pops them.
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
    logic [11:0] rgb;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic fs0, fs1, fs2;

  vga_if vif0 ();
  vga_if vif1 ();
  vga_if vif2 ();

  vga_timing u0 (
    .clk(clk), .rst(rst), .en(en), .frame_start(fs0), .out(vif0)
  );

  vga_timing #(
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(4), .V_BP(3)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .frame_start(fs1), .out(vif1)
  );

  vga_timing #(
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0)
  ) u2 (
    .clk(clk), .rst(rst), .en(en), .frame_start(fs2), .out(vif2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference raster per instance.
  int m_h[3], m_v[3], va[3], vf[3], vw[3], vt[3];
  bit m_fs[3], pl[3];

  function automatic void model_step(input int i, input bit r, input bit e);
    if (r) begin
      m_h[i] = 0; m_v[i] = 0; m_fs[i] = 1'b0;
    end else if (e) begin
      m_fs[i] = (m_h[i] == 1055) && (m_v[i] == vt[i] - 1);
      if (m_h[i] == 1055) begin
        m_h[i] = 0;
        m_v[i] = (m_v[i] == vt[i] - 1) ? 0 : m_v[i] + 1;
      end else begin
        m_h[i] = m_h[i] + 1;
      end
    end else begin
      m_fs[i] = 1'b0;
    end
  endfunction

  function automatic pix_t model_pix(input int i);
    pix_t p;
    p.h   = 11'(m_h[i]);
    p.v   = 11'(m_v[i]);
    p.hb  = (m_h[i] >= 800);
    p.hs  = (m_h[i] >= 840 && m_h[i] <= 967) ? pl[i] : !pl[i];
    p.vb  = (m_v[i] >= va[i]);
    p.vs  = (m_v[i] >= va[i] + vf[i] && m_v[i] < va[i] + vf[i] + vw[i]) ? pl[i] : !pl[i];
    p.fs  = m_fs[i];
    p.rgb = 12'h000;
    return p;
  endfunction

  pix_t sb0[$], sb1[$], sb2[$];

  // Monitor: every sampled cycle with an outstanding expectation is compared.
  always @(negedge clk) begin : mon
    pix_t g;
    if (sb0.size() > 0) begin
      g = '{h: vif0.hcount, v: vif0.vcount, hs: vif0.hsync, hb: vif0.hblnk,
            vs: vif0.vsync, vb: vif0.vblnk, fs: fs0, rgb: vif0.rgb};
      check("u0 pixel", 64'(g), 64'(sb0.pop_front()));
    end
    if (sb1.size() > 0) begin
      g = '{h: vif1.hcount, v: vif1.vcount, hs: vif1.hsync, hb: vif1.hblnk,
            vs: vif1.vsync, vb: vif1.vblnk, fs: fs1, rgb: vif1.rgb};
      check("u1 pixel", 64'(g), 64'(sb1.pop_front()));
    end
    if (sb2.size() > 0) begin
      g = '{h: vif2.hcount, v: vif2.vcount, hs: vif2.hsync, hb: vif2.hblnk,
            vs: vif2.vsync, vb: vif2.vblnk, fs: fs2, rgb: vif2.rgb};
      check("u2 pixel", 64'(g), 64'(sb2.pop_front()));
    end
  end

  // Run-wide trackers updated after every edge.
  int cyc = 0;
  int fs1_first = -1, fs1_cnt = 0, fs2_first = -1, fs2_cnt = 0;
  int vs2_low = 0, vb1_cnt = 0;
  int vs1_rise_h = -1, vs1_rise_v = -1, vs1_fall_h = -1, vs1_fall_v = -1;
  logic vs1_prev = 1'b0;

  task automatic cycle(input bit r, input bit e);
    rst = r;
    en  = e;
    for (int i = 0; i < 3; i++) model_step(i, r, e);
    sb0.push_back(model_pix(0));
    sb1.push_back(model_pix(1));
    sb2.push_back(model_pix(2));
    @(posedge clk);
    #2;
    if (r) begin
      cyc = 0;
    end else begin
      cyc++;
      if (fs1 === 1'b1) begin fs1_cnt++; if (fs1_first < 0) fs1_first = cyc; end
      if (fs2 === 1'b1) begin fs2_cnt++; if (fs2_first < 0) fs2_first = cyc; end
      if (cyc <= 16901 && vif2.vsync === 1'b0) vs2_low++;
      if (cyc <= 19013 && vif1.vblnk === 1'b1) vb1_cnt++;
      if (vif1.vsync && !vs1_prev && vs1_rise_h < 0) begin
        vs1_rise_h = vif1.hcount; vs1_rise_v = vif1.vcount;
      end
      if (!vif1.vsync && vs1_prev && vs1_fall_h < 0) begin
        vs1_fall_h = vif1.hcount; vs1_fall_v = vif1.vcount;
      end
    end
    vs1_prev = vif1.vsync;
  endtask

  int hs_cnt, hs_first, hs_last, hb_rise, hs2_cnt;

  initial begin
    va = '{600, 10, 10}; vf = '{1, 1, 1}; vw = '{4, 4, 2}; vt = '{628, 18, 16};
    pl = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin m_h[i] = 0; m_v[i] = 0; m_fs[i] = 1'b0; end

    // Reset state.
    cycle(1, 1);
    cycle(1, 1);
    check("reset hcount", vif0.hcount, 0);
    check("reset vcount", vif0.vcount, 0);
    check("reset hsync",  vif0.hsync, 0);
    check("reset vsync",  vif0.vsync, 0);
    check("reset hblnk",  vif0.hblnk, 0);
    check("reset vblnk",  vif0.vblnk, 0);
    check("reset frame_start", fs0, 0);
    check("reset rgb", vif0.rgb, 0);
    check("reset neg hsync", vif2.hsync, 1);
    check("reset neg vsync", vif2.vsync, 1);

    // Line 0 on the default instance.
    hs_cnt = 0; hs_first = -1; hs_last = -1; hb_rise = -1; hs2_cnt = 0;
    for (int k = 1; k <= 1056; k++) begin
      cycle(0, 1);
      if (vif0.hsync) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = vif0.hcount;
        hs_last = vif0.hcount;
      end
      if (vif0.hblnk && hb_rise < 0) hb_rise = vif0.hcount;
      if (!vif2.hsync) hs2_cnt++;
      if (k == 1) check("hcount at cycle 1", vif0.hcount, 1);
      if (k == 1055) begin
        check("hcount at cycle 1055", vif0.hcount, 1055);
        check("hblnk at 1055", vif0.hblnk, 1);
      end
    end
    check("hcount at cycle 1056", vif0.hcount, 0);
    check("vcount at cycle 1056", vif0.vcount, 1);
    check("hblnk falls at 0", vif0.hblnk, 0);
    check("hsync width", hs_cnt, 128);
    check("hsync first hcount", hs_first, 840);
    check("hsync last hcount", hs_last, 967);
    check("hblnk rise hcount", hb_rise, 800);
    check("neg hsync low width", hs2_cnt, 128);

    // Hold the raster for 5 cycles at hcount 500 of line 1.
    for (int n = 0; n < 3000 && !(m_h[1] == 500 && m_v[1] == 1); n++) cycle(0, 1);
    check("pre-hold hcount", vif1.hcount, 500);
    for (int n = 0; n < 5; n++) begin
      cycle(0, 0);
      check("held hcount", vif1.hcount, 500);
      check("held default hcount", vif0.hcount, 500);
    end
    cycle(0, 1);
    check("resume hcount", vif1.hcount, 501);

    // Finish the first short frame; the hold stretches it by 5 cycles.
    for (int n = 0; n < 20000 && cyc < 19013; n++) cycle(0, 1);
    check("frame_start cycle", fs1_first, 1056 * 18 + 5);
    check("frame_start count", fs1_cnt, 1);
    check("frame_start at wrap", fs1, 1);
    check("neg frame_start cycle", fs2_first, 1056 * 16 + 5);
    check("neg frame_start count", fs2_cnt, 1);
    check("neg vsync low cycles", vs2_low, 2 * 1056);
    check("vblnk cycles", vb1_cnt, 8 * 1056);
    check("vsync rise hcount", vs1_rise_h, 0);
    check("vsync rise vcount", vs1_rise_v, 11);
    check("vsync fall hcount", vs1_fall_h, 0);
    check("vsync fall vcount", vs1_fall_v, 15);
    cycle(0, 1);
    check("frame_start one cycle", fs1, 0);

    // Mid-frame reset at (900, 12).
    for (int n = 0; n < 20000 && !(m_h[1] == 900 && m_v[1] == 12); n++) cycle(0, 1);
    check("pre-reset hcount", vif1.hcount, 900);
    check("pre-reset vcount", vif1.vcount, 12);
    check("pre-reset vsync", vif1.vsync, 1);
    check("pre-reset hsync", vif1.hsync, 1);
    cycle(1, 1);
    check("mid reset hcount", vif1.hcount, 0);
    check("mid reset vcount", vif1.vcount, 0);
    check("mid reset hsync", vif1.hsync, 0);
    check("mid reset vsync", vif1.vsync, 0);
    check("mid reset hblnk", vif1.hblnk, 0);
    check("mid reset vblnk", vif1.vblnk, 0);
    cycle(0, 1);
    check("post reset hcount", vif1.hcount, 1);
    for (int n = 0; n < 1055; n++) cycle(0, 1);
    check("post reset line wrap hcount", vif1.hcount, 0);
    check("post reset line wrap vcount", vif1.vcount, 1);

    @(negedge clk);
    #1;
    check("scoreboard drained", sb0.size() + sb1.size() + sb2.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Source end of the vga_if pixel stream; every overlay stage downstream consumes it.
- Generates registered hcount/vcount, hsync/vsync and hblnk/vblnk for 800x600@60 Hz on a 40 MHz pixel clock.
- Drives rgb to black.
- Adds a one-cycle frame_start strobe and a pixel-enable input so the raster can be held for test or clock-domain pacing.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); line total H_TOT = 1056
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); frame total V_TOT = 628
- SYNC_POL, 1'b1, active level of hsync/vsync (1 = positive)

Ports:
- clk, input, 1, pixel clock (40 MHz)
- rst, input, 1, synchronous reset, active-high
- en, input, 1, pixel advance enable; all state holds when low
- frame_start, output, 1, one-cycle strobe when the raster is at (0,0)
- out, vga_if.out, -, fields vcount[10:0], hcount[10:0], vsync, vblnk, hsync, hblnk, rgb[11:0]

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous, active-high, on rst.
- All outputs are registered. There is no combinational path from en to any output.
- Reset values:
  - hcount = 0, vcount = 0.
  - hblnk = 0, vblnk = 0.
  - hsync = vsync = ~SYNC_POL (inactive).
  - rgb = 0, frame_start = 0.
- Counters:
  - On each clk with en = 1 and rst = 0, hcount advances 0..H_TOT-1.
  - At hcount = H_TOT-1, hcount wraps to 0 and vcount advances.
  - When vcount = V_TOT-1 at the same wrap, vcount wraps to 0.
  - Widths: 11 bits each. Compare and wrap against H_TOT-1 / V_TOT-1; never rely on natural overflow.
- Decode from the next counter values, registered in the same cycle as the counters, so that every out field describes the same (hcount, vcount) pixel:
  - hblnk = (hcount >= H_ACTIVE), i.e. 800..1055 by default.
  - hsync = SYNC_POL while H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (840..967); ~SYNC_POL otherwise.
  - vblnk = (vcount >= V_ACTIVE), i.e. 600..627.
  - vsync = SYNC_POL while V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (601..604); ~SYNC_POL otherwise.
  - vsync and vblnk change together with vcount, at hcount = 0 of the line.
- frame_start:
  - Registered; equals 1 for exactly the one cycle in which the out fields first present (0,0) after a frame wrap.
  - When en is low while at (0,0), frame_start deasserts after one cycle and does not re-fire until the next wrap.
  - frame_start is not asserted on the first (0,0) after reset.
- rgb: always 12'h000. Downstream stages paint over it.
- en low: hcount, vcount, sync and blank hold their values. Resuming continues the sequence with no skipped or repeated pixel.
- Reset mid-frame: on the next cycle all outputs take their reset values, and counting restarts at (0,0) on the following enabled cycle.
- Latency: with en high, each out field describes pixel (h, v) exactly one clk after the counter state for (h, v) is computed. Downstream registered stages add one cycle each and forward sync/blank unchanged.
- Elaboration check (assertion): every porch/sync parameter is > 0, and H_TOT / V_TOT are each < 2048.

Test Plan:
- Release rst with en = 1 held. Required:
  - hcount steps 0,1,2,..., reaching 1055 at cycle 1055 and 0 at cycle 1056.
  - vcount = 1 at cycle 1056.
  - No frame_start in the first frame.
- Horizontal decode over line 0:
  - hblnk rises at hcount = 800 and falls at 0.
  - hsync = 1 exactly for hcount 840..967; width is 128 cycles.
- Vertical decode over a full frame:
  - vblnk = 1 for vcount 600..627.
  - vsync = 1 for vcount 601..604, asserting and deasserting at hcount = 0.
  - frame_start pulses once, at cycle 1056*628 = 663168.
- Toggle en low for 5 cycles at hcount = 500, then restore. Required: outputs frozen at 500; next value 501; frame period extends by exactly 5 cycles.
- Assert rst for 1 cycle at (hcount 900, vcount 602). Required: next cycle hcount = vcount = 0, hsync = vsync = 0, hblnk = vblnk = 0; normal counting resumes.
- Run with SYNC_POL = 0 and V_SYNC = 2. Required: hsync low only for 840..967; vsync low only for vcount 601..602; rgb = 0 throughout.
